// File: rtl/cmp_result_packer.sv
// rtl/cmp_result_packer.sv - packs 1-bit comparator results LSB-first into W-bit words with hit statistics
module cmp_result_packer #(
    parameter int W     = 8,
    parameter int HIT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_bit,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_word,
    output logic [$clog2(W+1)-1:0]   out_count,
    output logic [$clog2(W+1)-1:0]   out_hits,
    input  logic                     clr_stats,
    output logic [HIT_W-1:0]         total_hits,
    output logic                     hits_ovf
);

    localparam int CW = $clog2(W+1);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FILL  = 1'b1;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    logic [0:0]    state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] acc_hits;

    logic          accept;
    logic          close;
    logic [CW-1:0] wr_pos;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] hits_next;
    logic [W-1:0]  hit_mask;
    logic [W-1:0]  acc_next;

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr_pos    = (state == S_EMPTY) ? '0 : cnt;
        cnt_next  = wr_pos + CW'(1);
        hits_next = ((state == S_EMPTY) ? '0 : acc_hits) + CW'(in_bit);
        hit_mask  = W'(in_bit) << wr_pos;
        acc_next  = ((state == S_EMPTY) ? '0 : acc) | hit_mask;
        close     = in_last | (cnt_next == CW'(W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            acc       <= '0;
            cnt       <= '0;
            acc_hits  <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_count <= '0;
            out_hits  <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (close) begin
                    // Closing bit goes straight into the output register.
                    out_word  <= acc_next;
                    out_count <= cnt_next;
                    out_hits  <= hits_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    acc_hits  <= '0;
                    state     <= S_EMPTY;
                end else begin
                    acc      <= acc_next;
                    cnt      <= cnt_next;
                    acc_hits <= hits_next;
                    state    <= S_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_hits <= '0;
            hits_ovf   <= 1'b0;
        end else if (clr_stats) begin
            total_hits <= '0;
            hits_ovf   <= 1'b0;
        end else if (accept && in_bit) begin
            if (total_hits == HIT_MAX) begin
                hits_ovf <= 1'b1;
            end else begin
                total_hits <= total_hits + HIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_packer.sv
// tb/tb_cmp_result_packer.sv - self-checking bench for cmp_result_packer
module tb_cmp_result_packer;

    localparam int W     = 8;
    localparam int HIT_W = 4;
    localparam int CW    = $clog2(W+1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
    logic in_ready, out_valid, hits_ovf;
    logic [W-1:0] out_word;
    logic [CW-1:0] out_count, out_hits;
    logic [HIT_W-1:0] total_hits;

    always #5 clk = ~clk;

    cmp_result_packer #(.W(W), .HIT_W(HIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_count(out_count), .out_hits(out_hits),
        .clr_stats(clr_stats), .total_hits(total_hits), .hits_ovf(hits_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending bits as a queue, words built when a word closes.
    bit   mq[$];
    bit   m_ov;
    int   m_word, m_count, m_hits, m_total;
    bit   m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 0; m_word = 0; m_count = 0; m_hits = 0; m_total = 0; m_ovf = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", int'(out_valid), int'(m_ov));
        check("out_word", int'(out_word), m_word);
        check("out_count", int'(out_count), m_count);
        check("out_hits", int'(out_hits), m_hits);
        check("total_hits", int'(total_hits), m_total);
        check("hits_ovf", int'(hits_ovf), int'(m_ovf));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; in_bit = 0; in_last = 0; out_ready = 0; clr_stats = 0;
        #1;
        model_reset();
        check_outputs();
        check("in_ready_rst", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
    task automatic cycle(input logic v, input logic b, input logic l, input logic r, input logic c);
        bit rdy, acc;
        in_valid = v; in_bit = b; in_last = l; out_ready = r; clr_stats = c;
        #1;
        rdy = !m_ov || r;
        check("in_ready", int'(in_ready), int'(rdy));
        acc = v && rdy;
        if (m_ov && r) m_ov = 0;
        if (acc) begin
            mq.push_back(b);
            if (l || mq.size() == W) begin
                m_word = 0; m_hits = 0;
                foreach (mq[i]) begin
                    m_word += int'(mq[i]) * (1 << i);
                    m_hits += int'(mq[i]);
                end
                m_count = mq.size();
                m_ov = 1;
                mq.delete();
            end
        end
        if (c) begin
            m_total = 0; m_ovf = 0;
        end else if (acc && b) begin
            if (m_total == (1 << HIT_W) - 1) m_ovf = 1;
            else m_total++;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        logic v, b, l, r;
        logic ev;
        logic [7:0] ew;
        int ec, eh, et;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 2};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 3};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 3};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h8D, 8, 4, 4};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 5};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 6};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 3, 2, 6};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1, 1, 7};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 7};

        @(negedge clk);
        do_reset();

        // Tests 1 and 2 from the vector table.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].r, 1'b0);
            check("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            check("tbl_total", int'(total_hits), tbl[i].et);
            if (tbl[i].ev) begin
                check("tbl_word", int'(out_word), int'(tbl[i].ew));
                check("tbl_count", int'(out_count), tbl[i].ec);
                check("tbl_hits", int'(out_hits), tbl[i].eh);
            end
        end

        // Backpressure: pending word holds, source stalls, then releases.
        do_reset();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_word_hold", int'(out_word), 8'h01);
            check("bp_count_hold", int'(out_count), 2);
        end
        cycle(1, 1, 1, 1, 0);
        check("bp_release_word", int'(out_word), 8'h01);
        check("bp_release_count", int'(out_count), 1);

        // Single-bit words stream without bubbles.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1'(i % 2), 1, 1, 0);
            check("stream_valid", int'(out_valid), 1);
            check("stream_count", int'(out_count), 1);
            check("stream_word", int'(out_word), i % 2);
        end

        // Saturation and clear-wins.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1, 1, 0, 1, 0);
        check("sat_total", int'(total_hits), 15);
        check("sat_ovf", int'(hits_ovf), 1);
        cycle(1, 1, 0, 1, 1);
        check("clr_total", int'(total_hits), 0);
        check("clr_ovf", int'(hits_ovf), 0);

        // Reset in the middle of a word.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 1'((8'hA4 >> i) & 1), 0, 1, 0);
        check("rst_word", int'(out_word), 8'hA4);
        check("rst_count", int'(out_count), 8);
        check("rst_hits", int'(out_hits), 3);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 6 == 0),
                  1'($urandom % 4 != 0), 1'($urandom % 60 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
